// File: rtl/bsg_front_side_bus_hop_out_rr_if.sv
// Handshake bundle for the round-robin FSB hop-out stage: channel inputs,
// per-channel accept, and the ready/valid output link.
interface bsg_front_side_bus_hop_out_rr_if #(
  parameter int width_p = 16,
  parameter int chan_p  = 2,
  localparam int lg_chan_lp = (chan_p <= 2) ? 1 : $clog2(chan_p)
);
  logic [chan_p-1:0]         v_i;
  logic [chan_p*width_p-1:0] data_i;
  logic [chan_p-1:0]         yumi_o;
  logic                      v_o;
  logic [width_p-1:0]        data_o;
  logic [lg_chan_lp-1:0]     src_o;
  logic                      ready_i;

  modport slave  (input v_i, data_i, ready_i, output yumi_o, v_o, data_o, src_o);
  modport master (output v_i, data_i, ready_i, input yumi_o, v_o, data_o, src_o);
endinterface

// File: rtl/bsg_front_side_bus_hop_out_rr.sv
// FSB hop-out: round-robin merge of chan_p valid/yumi channels into a
// fifo_els_p-deep output FIFO whose entries are tagged with the source channel.
module bsg_front_side_bus_hop_out_rr #(
  parameter int width_p    = 16,
  parameter int chan_p     = 2,
  parameter int fifo_els_p = 2,
  localparam int lg_chan_lp = (chan_p <= 2) ? 1 : $clog2(chan_p),
  localparam int lg_els_lp  = (fifo_els_p <= 2) ? 1 : $clog2(fifo_els_p),
  localparam int cnt_w_lp   = $clog2(fifo_els_p + 1)
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_front_side_bus_hop_out_rr_if.slave bus
);

  logic [lg_chan_lp-1:0]         rr_ptr_r;
  logic [cnt_w_lp-1:0]           count_r;
  logic [lg_els_lp-1:0]          head_r;
  logic [lg_els_lp-1:0]          tail_r;
  logic [lg_chan_lp+width_p-1:0] mem [fifo_els_p];

  logic [lg_chan_lp-1:0] winner_s;
  logic [width_p-1:0]    win_data_s;
  logic                  found_s;
  logic                  space_s;
  logic                  enq_s;
  logic                  deq_s;
  logic [chan_p-1:0]     yumi_s;
  logic [lg_chan_lp-1:0] rr_next_s;
  int unsigned           idx_s;

  // Cyclic priority scan starting at rr_ptr_r; yumi is held low during reset.
  always_comb begin
    winner_s   = '0;
    win_data_s = '0;
    found_s    = 1'b0;
    idx_s      = 32'd0;
    for (int k = 0; k < chan_p; k++) begin
      idx_s = 32'(rr_ptr_r) + 32'(k);
      if (idx_s >= 32'(chan_p)) begin
        idx_s = idx_s - 32'(chan_p);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && bus.v_i[idx_s]) begin
        found_s    = 1'b1;
        winner_s   = lg_chan_lp'(idx_s);
        win_data_s = bus.data_i[idx_s*width_p +: width_p];
      end else begin
        found_s    = found_s;
      end
    end
    space_s = (count_r < cnt_w_lp'(fifo_els_p));
    enq_s   = found_s & space_s & reset_n_i;
    deq_s   = (count_r != '0) & bus.ready_i;
    if (enq_s) begin
      yumi_s = chan_p'(1'b1) << winner_s;
    end else begin
      yumi_s = '0;
    end
    if (winner_s == lg_chan_lp'(chan_p - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = winner_s + lg_chan_lp'(1'b1);
    end
  end

  assign bus.yumi_o = yumi_s;
  assign bus.v_o    = (count_r != '0);
  assign bus.data_o = mem[head_r][width_p-1:0];
  assign bus.src_o  = mem[head_r][lg_chan_lp+width_p-1:width_p];

  // Arbitration pointer and FIFO bookkeeping.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= '0;
      tail_r   <= '0;
    end else begin
      if (enq_s) begin
        rr_ptr_r <= rr_next_s;
        if (tail_r == lg_els_lp'(fifo_els_p - 1)) begin
          tail_r <= '0;
        end else begin
          tail_r <= tail_r + lg_els_lp'(1'b1);
        end
      end
      if (deq_s) begin
        if (head_r == lg_els_lp'(fifo_els_p - 1)) begin
          head_r <= '0;
        end else begin
          head_r <= head_r + lg_els_lp'(1'b1);
        end
      end
      case ({enq_s, deq_s})
        2'b10:   count_r <= count_r + cnt_w_lp'(1'b1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Payload storage is deliberately left unreset; v_o qualifies it.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem[tail_r] <= {winner_s, win_data_s};
    end
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out_rr.sv
// Directed bench: instance a (2 channels, depth 2) and instance b (4 channels,
// depth 3) exercised by one task per scenario.
module tb_bsg_front_side_bus_hop_out_rr;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bsg_front_side_bus_hop_out_rr_if #(.width_p(16), .chan_p(2)) a_if ();
  bsg_front_side_bus_hop_out_rr_if #(.width_p(16), .chan_p(4)) b_if ();

  bsg_front_side_bus_hop_out_rr #(.width_p(16), .chan_p(2), .fifo_els_p(2)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .bus(a_if));
  bsg_front_side_bus_hop_out_rr #(.width_p(16), .chan_p(4), .fifo_els_p(3)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .bus(b_if));

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    a_if.v_i = 2'b11; a_if.data_i = 32'h1234_5678; a_if.ready_i = 1'b0;
    #1;
    vectors++; if (a_if.yumi_o !== 2'b00) begin miscompares++; $display("FAIL reset_yumi got %b exp 00", a_if.yumi_o); end
    vectors++; if (a_if.v_o !== 1'b0) begin miscompares++; $display("FAIL reset_v got %b exp 0", a_if.v_o); end
    vectors++; if (b_if.v_o !== 1'b0) begin miscompares++; $display("FAIL reset_b_v got %b exp 0", b_if.v_o); end
    a_if.v_i = 2'b00;
  endtask

  task automatic test_backpressure();
    do_reset();
    a_if.ready_i = 1'b0; a_if.v_i = 2'b11; a_if.data_i = {16'hB001, 16'hA000};
    #1;
    vectors++; if (a_if.yumi_o !== 2'b01) begin miscompares++; $display("FAIL bp_yumi1 got %b exp 01", a_if.yumi_o); end
    vectors++; if (a_if.v_o !== 1'b0) begin miscompares++; $display("FAIL bp_v1 got %b exp 0", a_if.v_o); end
    @(negedge clk); #1;
    vectors++; if (a_if.yumi_o !== 2'b10) begin miscompares++; $display("FAIL bp_yumi2 got %b exp 10", a_if.yumi_o); end
    vectors++; if (a_if.v_o !== 1'b1 || a_if.data_o !== 16'hA000 || a_if.src_o !== 1'b0) begin miscompares++; $display("FAIL bp_head1 got v=%b d=%h s=%b exp 1 a000 0", a_if.v_o, a_if.data_o, a_if.src_o); end
    @(negedge clk);
    a_if.ready_i = 1'b1; #1;
    vectors++; if (a_if.yumi_o !== 2'b00) begin miscompares++; $display("FAIL bp_full_yumi got %b exp 00", a_if.yumi_o); end
    vectors++; if (a_if.data_o !== 16'hA000) begin miscompares++; $display("FAIL bp_full_data got %h exp a000", a_if.data_o); end
    @(negedge clk);
    a_if.ready_i = 1'b0; a_if.data_i = {16'hB001, 16'hA002}; #1;
    vectors++; if (a_if.yumi_o !== 2'b01) begin miscompares++; $display("FAIL bp_after_deq_yumi got %b exp 01", a_if.yumi_o); end
    vectors++; if (a_if.data_o !== 16'hB001 || a_if.src_o !== 1'b1) begin miscompares++; $display("FAIL bp_head2 got d=%h s=%b exp b001 1", a_if.data_o, a_if.src_o); end
    @(negedge clk);
    a_if.v_i = 2'b00; a_if.ready_i = 1'b1; #1;
    vectors++; if (a_if.data_o !== 16'hB001) begin miscompares++; $display("FAIL bp_drain1 got %h exp b001", a_if.data_o); end
    @(negedge clk); #1;
    vectors++; if (a_if.data_o !== 16'hA002 || a_if.src_o !== 1'b0) begin miscompares++; $display("FAIL bp_drain2 got d=%h s=%b exp a002 0", a_if.data_o, a_if.src_o); end
    @(negedge clk); #1;
    vectors++; if (a_if.v_o !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %b exp 0", a_if.v_o); end
    a_if.ready_i = 1'b0;
  endtask

  task automatic test_reset_while_full();
    do_reset();
    a_if.ready_i = 1'b0; a_if.v_i = 2'b10; a_if.data_i = {16'h5151, 16'h5050};
    @(negedge clk);
    a_if.v_i = 2'b01;
    @(negedge clk);
    a_if.v_i = 2'b11; #1;
    vectors++; if (a_if.v_o !== 1'b1 || a_if.yumi_o !== 2'b00) begin miscompares++; $display("FAIL rf_full got v=%b y=%b exp 1 00", a_if.v_o, a_if.yumi_o); end
    #2 reset_n = 1'b0; #1;
    vectors++; if (a_if.v_o !== 1'b0) begin miscompares++; $display("FAIL rf_async_v got %b exp 0", a_if.v_o); end
    vectors++; if (a_if.yumi_o !== 2'b00) begin miscompares++; $display("FAIL rf_async_yumi got %b exp 00", a_if.yumi_o); end
    @(negedge clk);
    reset_n = 1'b1; #1;
    vectors++; if (a_if.yumi_o !== 2'b01 || a_if.v_o !== 1'b0) begin miscompares++; $display("FAIL rf_first_grant got y=%b v=%b exp 01 0", a_if.yumi_o, a_if.v_o); end
    @(negedge clk);
    a_if.v_i = 2'b00; #1;
    vectors++; if (a_if.v_o !== 1'b1 || a_if.data_o !== 16'h5050 || a_if.src_o !== 1'b0) begin miscompares++; $display("FAIL rf_head got v=%b d=%h s=%b exp 1 5050 0", a_if.v_o, a_if.data_o, a_if.src_o); end
    a_if.ready_i = 1'b1;
    @(negedge clk);
    a_if.ready_i = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    a_if.ready_i = 1'b0; a_if.v_i = 2'b10; a_if.data_i = {16'h1111, 16'h0000}; #1;
    vectors++; if (a_if.yumi_o !== 2'b10) begin miscompares++; $display("FAIL sim_yumi1 got %b exp 10", a_if.yumi_o); end
    @(negedge clk);
    a_if.ready_i = 1'b1; a_if.data_i = {16'h2222, 16'h0000}; #1;
    vectors++; if (a_if.yumi_o !== 2'b10) begin miscompares++; $display("FAIL sim_yumi2 got %b exp 10", a_if.yumi_o); end
    vectors++; if (a_if.data_o !== 16'h1111 || a_if.src_o !== 1'b1) begin miscompares++; $display("FAIL sim_old got d=%h s=%b exp 1111 1", a_if.data_o, a_if.src_o); end
    @(negedge clk);
    a_if.v_i = 2'b00; #1;
    vectors++; if (a_if.v_o !== 1'b1 || a_if.data_o !== 16'h2222) begin miscompares++; $display("FAIL sim_new got v=%b d=%h exp 1 2222", a_if.v_o, a_if.data_o); end
    @(negedge clk); #1;
    vectors++; if (a_if.v_o !== 1'b0) begin miscompares++; $display("FAIL sim_empty got %b exp 0", a_if.v_o); end
    a_if.ready_i = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] one;
    int exp_ch;
    int prev_ch;
    one = 4'b0001;
    do_reset();
    b_if.ready_i = 1'b1; b_if.v_i = 4'b0111;
    b_if.data_i = {16'hC003, 16'hC002, 16'hC001, 16'hC000};
    for (int n = 0; n < 6; n++) begin
      #1;
      exp_ch = n % 3;
      vectors++; if (b_if.yumi_o !== (one << exp_ch)) begin miscompares++; $display("FAIL rr_yumi[%0d] got %b exp %b", n, b_if.yumi_o, one << exp_ch); end
      if (n == 0) begin
        vectors++; if (b_if.v_o !== 1'b0) begin miscompares++; $display("FAIL rr_v0 got %b exp 0", b_if.v_o); end
      end else begin
        prev_ch = (n - 1) % 3;
        vectors++; if (b_if.v_o !== 1'b1 || b_if.src_o !== 2'(prev_ch) || b_if.data_o !== 16'hC000 + 16'(prev_ch)) begin miscompares++; $display("FAIL rr_out[%0d] got v=%b s=%0d d=%h exp 1 %0d c00%0d", n, b_if.v_o, b_if.src_o, b_if.data_o, prev_ch, prev_ch); end
      end
      @(negedge clk);
    end
    b_if.v_i = 4'b0000; #1;
    vectors++; if (b_if.src_o !== 2'd2 || b_if.data_o !== 16'hC002) begin miscompares++; $display("FAIL rr_last got s=%0d d=%h exp 2 c002", b_if.src_o, b_if.data_o); end
    @(negedge clk); #1;
    vectors++; if (b_if.v_o !== 1'b0) begin miscompares++; $display("FAIL rr_empty got %b exp 0", b_if.v_o); end
  endtask

  task automatic test_priority();
    do_reset();
    b_if.ready_i = 1'b1; b_if.v_i = 4'b0010; #1;
    vectors++; if (b_if.yumi_o !== 4'b0010) begin miscompares++; $display("FAIL pri_setup got %b exp 0010", b_if.yumi_o); end
    @(negedge clk);
    b_if.v_i = 4'b0001; #1;
    vectors++; if (b_if.yumi_o !== 4'b0001) begin miscompares++; $display("FAIL pri_lone got %b exp 0001", b_if.yumi_o); end
    @(negedge clk);
    b_if.v_i = 4'b1111; #1;
    vectors++; if (b_if.yumi_o !== 4'b0010) begin miscompares++; $display("FAIL pri_all got %b exp 0010", b_if.yumi_o); end
    @(negedge clk);
    b_if.v_i = 4'b0000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_wraparound();
    logic [15:0] rdy_pat;
    logic [3:0]  exp_y;
    logic        exp_v;
    int sent;
    int got;
    int cnt;
    rdy_pat = 16'b1100_0111_0000_1011;
    sent = 0; got = 0; cnt = 0;
    do_reset();
    for (int c = 0; c < 100 && got < 7; c++) begin
      b_if.v_i     = (sent < 7) ? 4'b0100 : 4'b0000;
      b_if.data_i  = {16'h0000, 16'(sent + 1), 32'h0000_0000};
      b_if.ready_i = rdy_pat[c % 16];
      #1;
      exp_y = (sent < 7 && cnt < 3) ? 4'b0100 : 4'b0000;
      exp_v = (cnt != 0);
      vectors++; if (b_if.yumi_o !== exp_y) begin miscompares++; $display("FAIL wrap_yumi[%0d] got %b exp %b", c, b_if.yumi_o, exp_y); end
      vectors++; if (b_if.v_o !== exp_v) begin miscompares++; $display("FAIL wrap_v[%0d] got %b exp %b", c, b_if.v_o, exp_v); end
      if (exp_v) begin
        vectors++; if (b_if.data_o !== 16'(got + 1) || b_if.src_o !== 2'd2) begin miscompares++; $display("FAIL wrap_data[%0d] got d=%h s=%0d exp %h 2", c, b_if.data_o, b_if.src_o, 16'(got + 1)); end
      end
      if (exp_y != 4'b0000) begin sent++; cnt++; end
      if (exp_v && b_if.ready_i) begin got++; cnt--; end
      @(negedge clk);
    end
    vectors++; if (got != 7) begin miscompares++; $display("FAIL wrap_total got %0d exp 7", got); end
    b_if.v_i = 4'b0000; b_if.ready_i = 1'b0;
  endtask

  initial begin
    b_if.v_i = 4'b0000; b_if.data_i = 64'h0; b_if.ready_i = 1'b0;
    test_reset();
    test_backpressure();
    test_reset_while_full();
    test_simultaneous();
    test_round_robin();
    test_priority();
    test_wraparound();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bsg_front_side_bus_hop_out_rr.md
Name: bsg_front_side_bus_hop_out_rr

Overview:
Parametrised successor to the two-input FSB hop-out stage. It merges chan_p valid/yumi input channels onto one width_p output link using round-robin arbitration, and buffers the result in a fifo_els_p-deep output FIFO. Each FIFO entry carries the id of its source channel. The block sits at each FSB node, between local/pass-through traffic and the next hop's ready/valid input.

Parameters:
width_p, 16, payload width per channel and on the output
chan_p, 2, number of input channels (>=2); lg_chan_lp = max(1, clog2(chan_p))
fifo_els_p, 2, output FIFO depth (>=2, need not be a power of two)

Ports:
clk_i  in  1  clock; all state updates on rising edge
reset_n_i  in  1  asynchronous, active-low reset
v_i  in  chan_p  per-channel valid
data_i  in  chan_p*width_p  channel i payload at bits [i*width_p +: width_p]
yumi_o  out  chan_p  one-hot (or zero) accept; channel i's payload is consumed this cycle
v_o  out  1  output valid (FIFO non-empty)
data_o  out  width_p  head entry payload
src_o  out  lg_chan_lp  channel id of head entry
ready_i  in  1  downstream ready; dequeue when v_o & ready_i

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (reset_n_i).
- Reset asserted (immediately, no clock needed):
  - rr_ptr_r=0, count_r=0, head_r=0, tail_r=0.
  - v_o=0; yumi_o forced to 0 regardless of v_i.
  - FIFO storage is not reset; data_o/src_o are don't-care while v_o=0.
- Reset mid-operation discards all buffered entries. Deassertion takes effect on the next clock edge.
- space = (count_r < fifo_els_p). No same-cycle enqueue into a full FIFO, even when a dequeue occurs that cycle.
- Arbitration (combinational):
  - The winner is the first i with v_i[i]=1, scanning rr_ptr_r, rr_ptr_r+1, ... cyclically mod chan_p.
  - yumi_o[winner] = space; all other yumi_o bits are 0.
  - If no v_i is set, or space=0, then yumi_o=0.
- Pointer update:
  - On any yumi: rr_ptr_r <= (winner+1) mod chan_p.
  - Otherwise rr_ptr_r holds. A blocked channel keeps its priority, so each requesting channel is served within chan_p grants.
- Enqueue (enq = |yumi_o):
  - mem[tail_r] <= {winner, data_i slice}.
  - tail_r <= tail_r+1, wrapping to 0 at fifo_els_p-1.
- Dequeue (deq = v_o & ready_i): head_r advances with the same wrap rule.
- Count: count_r += enq - deq. Simultaneous enq and deq leave count unchanged and are legal whenever count_r is in [1, fifo_els_p-1].
- Outputs:
  - v_o = (count_r != 0).
  - data_o/src_o = mem[head_r] (registered storage, no input-to-output combinational path).
- Latency: yumi in cycle N gives v_o/data visible in cycle N+1 when the FIFO was empty. No bypass.
- Inputs need not hold stable: v_i may drop without yumi; no input-side obligation exists beyond valid/yumi.
- Ordering: the output order equals grant order. A single channel's entries are never reordered.
- ready_i may toggle freely. data_o/src_o stay stable while v_o=1 and ready_i=0.
- chan_p=2 gives alternating service under continuous contention, which replaces the old blocked-flag scheme.

Test Plan:
- Reset while full: fill fifo_els_p=2, assert reset_n_i=0 mid-cycle -> v_o=0 and yumi_o=0 immediately, without a clock edge. After release, first yumi goes to channel 0.
- Round-robin contention: chan_p=3, v_i=3'b111 held, ready_i=1 every cycle -> yumi_o sequence 001,010,100,001... src_o one cycle later 0,1,2,0; each data_o matches the granted channel's data_i.
- Backpressure and full: ready_i=0, v_i=2'b11, fifo_els_p=2 -> two grants (ch0, ch1), then yumi_o=0 with count=2. Raise ready_i for one cycle -> one dequeue, no enqueue that cycle; grant to ch0 the following cycle.
- Simultaneous enq/deq at count=1: v_i[1]=1, ready_i=1 -> count stays 1, tail and head both advance; data_o shows the older entry, then the newer.
- Wrap-around with non-power-of-two depth: fifo_els_p=3, 7 sequential single-channel payloads 0x0001..0x0007 under random ready_i -> output exactly 0x0001..0x0007 in order, with head/tail wrapping 2->0.
- Priority retention: chan_p=4, rr_ptr=2, v_i=4'b0001 granted, next cycle v_i=4'b1111 -> grant ch1 (pointer became 1), not ch0.
